// File: rtl/instr_encoder.sv
// RV32I instruction encoder: encode register feeding a DEPTH-entry FIFO with a registered head.
// Optional macro ENC_RANGE_CHECK_EN flags immediates that do not fit their instruction field.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [2:0]  in_func3,
  input  logic        in_alt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        enc_err,
  output logic [15:0] enc_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  localparam logic [3:0] KIND_R      = 4'd0;
  localparam logic [3:0] KIND_IALU   = 4'd1;
  localparam logic [3:0] KIND_LOAD   = 4'd2;
  localparam logic [3:0] KIND_STORE  = 4'd3;
  localparam logic [3:0] KIND_BRANCH = 4'd4;
  localparam logic [3:0] KIND_JAL    = 4'd5;
  localparam logic [3:0] KIND_JALR   = 4'd6;
  localparam logic [3:0] KIND_LUI    = 4'd7;
  localparam logic [3:0] KIND_AUIPC  = 4'd8;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        in_ready_q, in_ready_d;
  logic        enc_valid_q, enc_valid_d;
  logic [31:0] enc_instr_q, enc_instr_d;
  logic [31:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        enc_err_q, enc_err_d;
  logic [15:0] enc_count_q, enc_count_d;

  logic [31:0] enc_word;
  logic        kind_bad;
  logic        range_bad;
  logic        is_shift;
  logic        accept, pop, push, head_load;

  assign is_shift = (in_func3 == 3'd1) || (in_func3 == 3'd5);

  // Field packing for each instruction format; illegal kinds become a NOP.
  always_comb begin
    enc_word = NOP_WORD;
    kind_bad = 1'b0;
    case (in_kind)
      KIND_R:      enc_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_func3, in_rd, 7'h33};
      KIND_IALU:   enc_word = is_shift ?
                              {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, 7'h13} :
                              {in_imm[11:0], in_rs1, in_func3, in_rd, 7'h13};
      KIND_LOAD:   enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, 7'h03};
      KIND_STORE:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], 7'h23};
      KIND_BRANCH: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                               in_imm[4:1], in_imm[11], 7'h63};
      KIND_JAL:    enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
      KIND_JALR:   enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
      KIND_LUI:    enc_word = {in_imm[31:12], in_rd, 7'h37};
      KIND_AUIPC:  enc_word = {in_imm[31:12], in_rd, 7'h17};
      default:     kind_bad = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic fit12, fit13, fit21;

  // Immediate representability per format; the truncated word is still emitted.
  always_comb begin
    fit12     = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    fit13     = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    fit21     = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
    range_bad = 1'b0;
    case (in_kind)
      KIND_IALU:   range_bad = is_shift ? (in_imm[31:5] != '0) : !fit12;
      KIND_LOAD,
      KIND_STORE,
      KIND_JALR:   range_bad = !fit12;
      KIND_BRANCH: range_bad = !fit13 || in_imm[0];
      KIND_JAL:    range_bad = !fit21 || in_imm[0];
      KIND_LUI,
      KIND_AUIPC:  range_bad = (in_imm[11:0] != '0);
      default:     range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  // Pipe control: pushes always land in the FIFO body, the head reloads from it.
  always_comb begin
    accept    = in_valid && in_ready_q;
    pop       = out_valid_q && out_ready;
    push      = enc_valid_q;
    head_load = (mem_cnt_q != '0) && (!out_valid_q || pop);

    enc_valid_d = accept;
    enc_instr_d = accept ? enc_word : enc_instr_q;

    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = head_load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CNT_W'(push) - CNT_W'(head_load);

    out_valid_d = head_load ? 1'b1 : (pop ? 1'b0 : out_valid_q);
    out_instr_d = head_load ? mem_q[rd_ptr_q] : out_instr_q;
    out_addr_d  = pop ? out_addr_q + 32'd4 : out_addr_q;
    enc_count_d = pop ? enc_count_q + 16'd1 : enc_count_q;

    enc_err_d  = enc_err_q | (accept & (kind_bad | range_bad));
    in_ready_d = (OCC_W'(mem_cnt_d) + OCC_W'(out_valid_d) + OCC_W'(enc_valid_d)) < OCC_W'(DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_instr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      enc_err_q   <= 1'b0;
      enc_count_q <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      enc_valid_q <= enc_valid_d;
      enc_instr_q <= enc_instr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      enc_err_q   <= enc_err_d;
      enc_count_q <= enc_count_d;
    end
  end

  // FIFO body storage needs no reset; occupancy is tracked by mem_cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_instr_q;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign enc_err   = enc_err_q;
  assign enc_count = enc_count_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, address of the first emitted instruction word.
REQ-002 SHALL have parameter DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-003 SHALL have ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-004 SHALL have in_valid input 1 (request present) and in_ready output 1 (request accepted when both high at clk edge).
REQ-005 SHALL have in_kind input 4, format: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9-15 illegal.
REQ-006 SHALL have in_func3 input 3, in_alt input 1 (func7 bit 5 for R/shift), in_rd, in_rs1, in_rs2 inputs 5 each, in_imm input 32 (signed byte offset, or full 32-bit value for LUI/AUIPC).
REQ-007 SHALL have out_valid output 1, out_ready input 1, out_instr output 32 (RV32I word), out_addr output 32 (word address of out_instr).
REQ-008 SHALL have enc_err output 1 (sticky error) and enc_count output 16 (instructions emitted, wraps).

Function
REQ-009 SHALL be a two-stage pipe: encode register, then DEPTH-entry FIFO with registered head; a request accepted at edge N is visible on out_instr after edge N+2 at earliest.
REQ-010 SHALL drive in_ready = (FIFO occupancy + encode-stage valid) < DEPTH; no accepted request is ever dropped or reordered.
REQ-011 SHALL encode R as {1'b0,in_alt,5'b0,rs2,rs1,func3,rd,7'h33}.
REQ-012 SHALL encode I-ALU as {imm[11:0],rs1,func3,rd,7'h13}; for func3 1 or 5, bits 31:20 SHALL be {1'b0,in_alt,5'b0,imm[4:0]}.
REQ-013 SHALL encode LOAD (7'h03) and JALR (7'h67, func3 forced 0) as I-format; STORE (7'h23) as {imm[11:5],rs2,rs1,func3,imm[4:0]}.
REQ-014 SHALL encode BRANCH (7'h63) as {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11]}; JAL (7'h6F) as {imm[20],imm[10:1],imm[11],imm[19:12],rd}.
REQ-015 SHALL encode LUI (7'h37) and AUIPC (7'h17) as {imm[31:12],rd,opcode}.
REQ-016 SHALL emit 32'h0000_0013 (NOP) for illegal in_kind and set enc_err.
REQ-017 SHALL start out_addr at BASE_ADDR, add 4 on each out_valid&&out_ready, wrap modulo 2^32; enc_count increments on the same event.
REQ-018 SHALL hold out_instr/out_addr stable while out_valid=1 and out_ready=0.
REQ-019 SHALL allow simultaneous FIFO push and pop in one cycle, including at full.
REQ-020 SHALL clear enc_err only by reset.

Reset
REQ-021 SHALL, on reset (asynchronous, any cycle): out_valid=0, out_instr=0, out_addr=BASE_ADDR, enc_count=0, enc_err=0, encode stage and FIFO emptied; in-flight requests discarded.
REQ-022 SHALL drive in_ready=1 from the first clk edge after reset deasserts.

Configuration
REQ-023 SHALL, with ENC_RANGE_CHECK_EN defined, set enc_err when the immediate is unrepresentable: I/LOAD/STORE/JALR outside signed 12 bits; BRANCH outside signed 13 bits or imm[0]=1; JAL outside signed 21 bits or imm[0]=1; shift imm[31:5]!=0; LUI/AUIPC imm[11:0]!=0.
REQ-024 SHALL, in both builds, still emit the truncated encoding; without the macro, enc_err reflects illegal in_kind only.

Verification
REQ-025 SHALL check R ADD rd=1 rs1=2 rs2=3 -> out_instr 32'h003100B3, out_addr BASE_ADDR.
REQ-026 SHALL check I-ALU func3=0 rd=5 rs1=0 imm=-1 -> 32'hFFF00293; STORE func3=2 rs1=2 rs2=6 imm=8 -> 32'h00612423.
REQ-027 SHALL check BRANCH func3=0 rs1=1 rs2=2 imm=-4 -> 32'hFE208EE3.
REQ-028 SHALL check out_ready=0 with 6 requests offered -> exactly DEPTH accepted, in_ready=0; then out_ready=1 -> all 6 emitted in order at addresses 0,4,8,...,20, enc_count=6.
REQ-029 SHALL check I-ALU imm=2048 rd=0 rs1=0 -> 32'h80000013; enc_err=1 with ENC_RANGE_CHECK_EN, 0 without; in_kind=12 -> 32'h00000013, enc_err=1 both builds.
REQ-030 SHALL check reset asserted with 3 entries buffered -> out_valid=0 immediately, out_addr=BASE_ADDR, no stale word emitted after release.
